mem_stage_unit: RTL and testbench

- Memory-stage controller of the 32-bit pipelined core.
- Consumes the Execute-to-Memory register outputs: WA3M, WriteDataM, ALUResultM and the M-stage control bits.
- Drives a req/ack data-memory port and stalls upstream stages while an access is outstanding.
- Contains the Memory-to-Writeback pipeline register that feeds register-file writeback.

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_stage_unit_pipe_mem_to_wb.sv | 58 +++++
 rtl/mem_stage_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_stage_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : mem_stage_pkg
// Brief    : Shared types and constants for the memory-stage controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // W-stage bundle field widths
    localparam int WA_W      = 4;
    localparam int WB_CTRL_W = 3;

endpackage

`default_nettype wire

// File: rtl/mem_stage_unit_pipe_mem_to_wb.sv
//------------------------------------------------------------------------------
// Module   : pipe_mem_to_wb
// Brief    : MEM/WB pipeline register; loads the presented value every cycle,
//            or an all-zero bubble when requested.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_mem_to_wb
    import mem_stage_pkg::*;
#(
    parameter int bits = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble,
    input  logic              regwrite_d,
    input  logic              memtoreg_d,
    input  logic              memerr_d,
    input  logic [WA_W-1:0]   wa3_d,
    input  logic [bits-1:0]   readdata_d,
    input  logic [bits-1:0]   aluout_d,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              MemErrW,
    output logic [WA_W-1:0]   WA3W,
    output logic [bits-1:0]   ReadDataW,
    output logic [bits-1:0]   ALUOutW
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            MemErrW   <= 1'b0;
            WA3W      <= '0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
        end else if (bubble) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            MemErrW   <= 1'b0;
            WA3W      <= '0;
            ReadDataW <= '0;
            ALUOutW   <= '0;
        end else begin
            RegWriteW <= regwrite_d;
            MemtoRegW <= memtoreg_d;
            MemErrW   <= memerr_d;
            WA3W      <= wa3_d;
            ReadDataW <= readdata_d;
            ALUOutW   <= aluout_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage_unit.sv
//------------------------------------------------------------------------------
// Module   : mem_stage_unit
// Brief    : Memory-stage controller: req/ack data-memory FSM with timeout,
//            upstream stall generation and the MEM/WB register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int bits    = 32,
    parameter int AW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic [WA_W-1:0]   WA3M,
    input  logic [bits-1:0]   ALUResultM,
    input  logic [bits-1:0]   WriteDataM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [bits-1:0]   mem_wdata,
    input  logic [bits-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [WA_W-1:0]   WA3W,
    output logic [bits-1:0]   ReadDataW,
    output logic [bits-1:0]   ALUOutW,
    output logic              MemErrW
);

    localparam int            CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] c_last = CW'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;

    logic            w_memop;
    logic            w_misalign;
    logic            w_timeout_hit;
    logic            w_issue;
    logic            w_retire;
    logic            w_bubble;
    logic            w_regwrite;
    logic            w_memerr;
    logic [bits-1:0] w_readdata;

    assign w_memop       = MemReadM | MemWriteM;
    assign w_misalign    = w_memop & (|(ALUResultM[1:0] & ALIGN_MASK));
    // An ack arriving in the last counted cycle wins over the timeout
    assign w_timeout_hit = (r_state == ACCESS) & (r_count == c_last) & ~mem_ack;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        StallM      = 1'b0;
        w_issue     = 1'b0;
        w_retire    = 1'b0;
        w_bubble    = 1'b1;
        w_regwrite  = RegWriteM;
        w_memerr    = 1'b0;
        w_readdata  = '0;

        case (r_state)
            IDLE: begin
                if (!w_memop) begin
                    w_bubble = 1'b0;
                end else if (w_misalign) begin
                    w_bubble   = 1'b0;
                    w_regwrite = 1'b0;
                    w_memerr   = 1'b1;
                end else begin
                    StallM      = 1'b1;
                    w_issue     = 1'b1;
                    w_count_nxt = '0;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    w_bubble    = 1'b0;
                    w_retire    = 1'b1;
                    w_readdata  = mem_we ? '0 : mem_rdata;
                    w_state_nxt = IDLE;
                end else if (w_timeout_hit) begin
                    w_bubble    = 1'b0;
                    w_retire    = 1'b1;
                    w_regwrite  = 1'b0;
                    w_memerr    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    StallM      = 1'b1;
                    w_count_nxt = r_count + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Request registers stay frozen for the whole access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (w_issue) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= ALUResultM[AW+1:2];
            mem_wdata <= WriteDataM;
        end else if (w_retire) begin
            mem_req   <= 1'b0;
        end
    end

    pipe_mem_to_wb #(
        .bits (bits)
    ) u_pipe_mem_to_wb (
        .clk        (clk),
        .rst        (rst),
        .bubble     (w_bubble),
        .regwrite_d (w_regwrite),
        .memtoreg_d (MemtoRegM),
        .memerr_d   (w_memerr),
        .wa3_d      (WA3M),
        .readdata_d (w_readdata),
        .aluout_d   (ALUResultM),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .MemErrW    (MemErrW),
        .WA3W       (WA3W),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_stage_unit
// Brief    : Directed self-checking bench for mem_stage_unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage_unit;

    logic        clk;
    logic        rst;
    logic        MemReadM, MemWriteM, RegWriteM, MemtoRegM;
    logic [3:0]  WA3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        StallM;
    logic        RegWriteW, MemtoRegW, MemErrW;
    logic [3:0]  WA3W;
    logic [31:0] ReadDataW, ALUOutW;

    int n_total = 0;
    int n_pass  = 0;
    int stalls;

    mem_stage_unit #(
        .bits    (32),
        .AW      (16),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .WA3M       (WA3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .StallM     (StallM),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .WA3W       (WA3W),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW),
        .MemErrW    (MemErrW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic [3:0] wa, input logic [31:0] alu, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        RegWriteM  = rw;
        MemtoRegM  = m2r;
        WA3M       = wa;
        ALUResultM = alu;
        WriteDataM = wd;
    endtask

    // Runs an aligned memop from its IDLE cycle to retire; ack_cyc is the
    // 1-based ACCESS cycle carrying mem_ack (0 = never). Counts stall cycles
    // and flags any change of the request registers during ACCESS.
    task automatic run_mem(input int ack_cyc, input logic [31:0] rdata,
                           input logic [15:0] exp_addr, input logic exp_we,
                           input logic [31:0] exp_wd, output int n_stall);
        logic was_stall;
        logic bad;
        logic done;
        n_stall = 0;
        bad     = 1'b0;
        done    = 1'b0;
        #1;
        if (StallM) n_stall++;
        tick();
        for (int c = 1; c <= 40 && !done; c++) begin
            if (c == ack_cyc) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            #1;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== exp_we ||
                mem_wdata !== exp_wd) bad = 1'b1;
            was_stall = StallM;
            if (was_stall) n_stall++;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            if (!was_stall) done = 1'b1;
        end
        check("access_done_in_budget", {31'b0, done}, 32'd1);
        check("req_regs_held", {31'b0, bad}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        #2;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_stall", {31'b0, StallM}, 32'd0);
        check("rst_wb", {RegWriteW, MemtoRegW, MemErrW, WA3W, ALUOutW[24:0]}, 32'd0);
        check("rst_readdata", ReadDataW, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // ALU op retires in one cycle
        set_m(0, 0, 1, 0, 4'h3, 32'h0000_0010, 32'h0);
        #1;
        check("alu_stall", {31'b0, StallM}, 32'd0);
        tick();
        check("alu_regwrite", {31'b0, RegWriteW}, 32'd1);
        check("alu_wa3", {28'b0, WA3W}, 32'd3);
        check("alu_aluout", ALUOutW, 32'h10);
        check("alu_no_req", {31'b0, mem_req}, 32'd0);

        // Load, ack in first ACCESS cycle
        set_m(1, 0, 1, 1, 4'h5, 32'h0000_0104, 32'h0);
        run_mem(1, 32'hDEAD_BEEF, 16'h0041, 1'b0, 32'h0, stalls);
        check("load_stalls", stalls, 32'd1);
        check("load_readdata", ReadDataW, 32'hDEAD_BEEF);
        check("load_wa3", {28'b0, WA3W}, 32'd5);
        check("load_ctrl", {29'b0, RegWriteW, MemtoRegW, MemErrW}, 32'b110);
        check("load_req_dropped", {31'b0, mem_req}, 32'd0);
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Store, ack delayed 4 cycles
        set_m(0, 1, 0, 0, 4'h0, 32'h0000_0020, 32'h1234_5678);
        run_mem(5, 32'hFFFF_FFFF, 16'h0008, 1'b1, 32'h1234_5678, stalls);
        check("store_stalls", stalls, 32'd5);
        check("store_wb", {30'b0, RegWriteW, MemErrW}, 32'd0);
        check("store_readdata", ReadDataW, 32'd0);
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Read+write together: write wins, no read data
        set_m(1, 1, 1, 1, 4'h6, 32'h0000_0030, 32'hA5A5_A5A5);
        run_mem(2, 32'h1111_1111, 16'h000C, 1'b1, 32'hA5A5_A5A5, stalls);
        check("rw_stalls", stalls, 32'd2);
        check("rw_readdata", ReadDataW, 32'd0);
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Misaligned load
        set_m(1, 0, 1, 1, 4'h2, 32'h0000_0022, 32'h0);
        #1;
        check("mis_stall", {31'b0, StallM}, 32'd0);
        tick();
        check("mis_no_req", {31'b0, mem_req}, 32'd0);
        check("mis_wb", {30'b0, RegWriteW, MemErrW}, 32'b01);
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        check("mis_err_not_sticky", {31'b0, MemErrW}, 32'd0);

        // Load with no ack: timeout
        set_m(1, 0, 1, 1, 4'h7, 32'h0000_0040, 32'h0);
        run_mem(0, 32'h0, 16'h0010, 1'b0, 32'h0, stalls);
        check("to_stalls", stalls, 32'd15);
        check("to_wb", {30'b0, RegWriteW, MemErrW}, 32'b01);
        check("to_req_dropped", {31'b0, mem_req}, 32'd0);
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        check("to_err_not_sticky", {31'b0, MemErrW}, 32'd0);

        // Ack on the 15th ACCESS cycle beats timeout
        set_m(1, 0, 1, 1, 4'h8, 32'h0000_0044, 32'h0);
        run_mem(15, 32'hCAFE_F00D, 16'h0011, 1'b0, 32'h0, stalls);
        check("late_ack_stalls", stalls, 32'd15);
        check("late_ack_wb", {30'b0, RegWriteW, MemErrW}, 32'b10);
        check("late_ack_readdata", ReadDataW, 32'hCAFE_F00D);
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Reset in the 3rd ACCESS cycle
        tick();
        set_m(1, 0, 1, 1, 4'h4, 32'h0000_0080, 32'h0);
        tick();
        tick();
        tick();
        check("pre_rst_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_req", {31'b0, mem_req}, 32'd0);
        check("rst_mid_wb", {RegWriteW, MemtoRegW, MemErrW, WA3W, ALUOutW[24:0]}, 32'd0);
        set_m(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        #1;
        check("stray_ack_stall", {31'b0, StallM}, 32'd0);
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check("stray_ack_req", {31'b0, mem_req}, 32'd0);
        check("stray_ack_readdata", ReadDataW, 32'd0);
        set_m(0, 0, 1, 0, 4'h9, 32'h0000_0055, 32'h0);
        tick();
        check("post_rst_alu", {RegWriteW, 3'b0, WA3W, ALUOutW[23:0]}, {1'b1, 3'b0, 4'h9, 24'h000055});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
